// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver states, oversampling ratio, baud divider helper.
// Pure declarations; no latency or backpressure.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  localparam int OVERSAMPLE = 16;

  // Clocks per oversample tick, truncated; shared with the transmit path.
  function automatic int calc_tick_div(input int clock_rate, input int baud_rate);
    return clock_rate / (baud_rate * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_os_tick.sv
// 16x oversampling tick: one-cycle tick_o every TICK_DIV clocks, restartable via clr_i.
// Tick is combinational from the counter; no backpressure.
module uart_os_tick
  import uart_pkg::*;
#(
  parameter int CLOCK_RATE = 50000000,
  parameter int BAUD_RATE  = 9600
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int TICK_DIV = calc_tick_div(CLOCK_RATE, BAUD_RATE);
  localparam int CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  assign tick_o = (cnt_q == TICK_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (tick_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, 16x oversampled, 2-flop input synchronizer.
// rxdone_o/rxerr_o strobe 1 clk after the mid-stop tick; no backpressure, strobes are not held.
module uart_rx #(
  parameter int CLOCK_RATE = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  input  logic       rxen_i,
  output logic [7:0] rxdata_o,
  output logic       rxdone_o,
  output logic       rxerr_o,
  output logic       rxbusy_o
);
  import uart_pkg::*;

  localparam int SCW = $clog2(OVERSAMPLE);
  localparam logic [SCW-1:0] SC_MID  = SCW'(OVERSAMPLE / 2 - 1);
  localparam logic [SCW-1:0] SC_LAST = SCW'(OVERSAMPLE - 1);

  logic [1:0]     sync_q;
  logic           rx_s;
  state_t         state_q, state_d;
  logic [SCW-1:0] sc_q, sc_d;
  logic [2:0]     bc_q, bc_d;
  logic [7:0]     shreg_q, shreg_d;
  logic [7:0]     data_d;
  logic           done_d, err_d;
  logic           tick, clr;

  assign rx_s     = sync_q[1];
  assign rxbusy_o = (state_q != IDLE);

  uart_os_tick #(
    .CLOCK_RATE(CLOCK_RATE),
    .BAUD_RATE (BAUD_RATE)
  ) u_tick (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (clr),
    .tick_o(tick)
  );

  always_comb begin
    state_d = state_q;
    sc_d    = sc_q;
    bc_d    = bc_q;
    shreg_d = shreg_q;
    data_d  = rxdata_o;
    done_d  = 1'b0;
    err_d   = 1'b0;
    clr     = 1'b0;
    case (state_q)
      IDLE: begin
        // Restart the tick counter so mid-bit sampling lines up with the start edge.
        if (rxen_i && !rx_s) begin
          state_d = START;
          sc_d    = '0;
          clr     = 1'b1;
        end
      end
      START: begin
        if (!rxen_i) begin
          state_d = IDLE;
        end else if (tick) begin
          if (sc_q == SC_MID) begin
            sc_d    = '0;
            bc_d    = '0;
            state_d = rx_s ? IDLE : DATA;
          end else begin
            sc_d = sc_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (!rxen_i) begin
          state_d = IDLE;
        end else if (tick) begin
          sc_d = sc_q + 1'b1;
          if (sc_q == SC_LAST) begin
            shreg_d[bc_q] = rx_s;
            if (bc_q == 3'd7) begin
              state_d = STOP;
            end else begin
              bc_d = bc_q + 3'd1;
            end
          end
        end
      end
      STOP: begin
        if (!rxen_i) begin
          state_d = IDLE;
        end else if (tick) begin
          sc_d = sc_q + 1'b1;
          if (sc_q == SC_LAST) begin
            if (rx_s) begin
              data_d  = shreg_q;
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              err_d   = 1'b1;
              state_d = BREAK;
            end
          end
        end
      end
      BREAK: begin
        // Wait out a held-low line so it cannot look like a fresh start bit.
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q   <= 2'b11;
      state_q  <= IDLE;
      sc_q     <= '0;
      bc_q     <= '0;
      shreg_q  <= '0;
      rxdata_o <= '0;
      rxdone_o <= 1'b0;
      rxerr_o  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], rx_i};
      state_q  <= state_d;
      sc_q     <= sc_d;
      bc_q     <= bc_d;
      shreg_q  <= shreg_d;
      rxdata_o <= data_d;
      rxdone_o <= done_d;
      rxerr_o  <= err_d;
    end
  end

endmodule
